// File: rtl/imm_gen_pipe.sv
// LEGv8 decode-stage immediate generator behind a two-entry skid buffer.
// Define IMM_GEN_IW_EN to decode the MOVZ/MOVK wide-immediate (IW) format.
module imm_gen_pipe #(
   parameter int INST_W = 32,
   parameter int DATA_W = 64,
   parameter int TAG_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [5:0]        in_imm_op,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_imm,
   output logic              out_err,
   output logic [TAG_W-1:0]  out_tag
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] out_imm_reg, skid_imm_reg, calc_imm;
   logic              out_err_reg, skid_err_reg, calc_err;
   logic [TAG_W-1:0]  out_tag_reg, skid_tag_reg;
   logic              accept, drain, multi_hot;
   logic              load_out, load_skid, skid_to_out;
   logic              unused_inst_bits;

   // Opcode bits [31:26] select the format upstream; only the operand field matters here.
   assign unused_inst_bits = ^in_inst[INST_W-1:26];

   assign multi_hot = |(in_imm_op & (in_imm_op - 6'd1));

`ifdef IMM_GEN_IW_EN
   logic [63:0] iw_wide;
   assign iw_wide = {48'd0, in_inst[20:5]} << {in_inst[22:21], 4'd0};
`endif

   always_comb begin
      calc_imm = '0;
      calc_err = 1'b0;
      if (multi_hot) begin
         calc_err = 1'b1;
      end else if (in_imm_op[5]) begin
`ifdef IMM_GEN_IW_EN
         // A 32-bit datapath cannot hold halfword 2 or 3.
         if (DATA_W == 32 && in_inst[22])
            calc_err = 1'b1;
         else
            calc_imm = iw_wide[DATA_W-1:0];
`else
         calc_err = 1'b1;
`endif
      end else if (in_imm_op[4]) begin
         calc_imm = {{(DATA_W-26){in_inst[25]}}, in_inst[25:0]};
      end else if (in_imm_op[3]) begin
         calc_imm = {{(DATA_W-19){in_inst[23]}}, in_inst[23:5]};
      end else if (in_imm_op[2]) begin
         calc_imm = {{(DATA_W-12){in_inst[21]}}, in_inst[21:10]};
      end else if (in_imm_op[1]) begin
         calc_imm = {{(DATA_W-6){1'b0}}, in_inst[15:10]};
      end else if (in_imm_op[0]) begin
         calc_imm = {{(DATA_W-9){in_inst[20]}}, in_inst[20:12]};
      end
   end

   // in_ready comes from registered state only, never from out_ready.
   assign in_ready  = (state_reg != TWO) && !rst;
   assign out_valid = (state_reg != EMPTY);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   always_comb begin
      state_next  = state_reg;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: if (accept) begin
               state_next = ONE;
               load_out   = 1'b1;
            end
            ONE: if (accept && drain) begin
               load_out = 1'b1;
            end else if (accept) begin
               state_next = TWO;
               load_skid  = 1'b1;
            end else if (drain) begin
               state_next = EMPTY;
            end
            TWO: if (drain) begin
               state_next  = ONE;
               skid_to_out = 1'b1;
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= EMPTY;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_imm_reg  <= '0;
         out_err_reg  <= 1'b0;
         out_tag_reg  <= '0;
         skid_imm_reg <= '0;
         skid_err_reg <= 1'b0;
         skid_tag_reg <= '0;
      end else begin
         if (load_out) begin
            out_imm_reg <= calc_imm;
            out_err_reg <= calc_err;
            out_tag_reg <= in_tag;
         end else if (skid_to_out) begin
            out_imm_reg <= skid_imm_reg;
            out_err_reg <= skid_err_reg;
            out_tag_reg <= skid_tag_reg;
         end
         if (load_skid) begin
            skid_imm_reg <= calc_imm;
            skid_err_reg <= calc_err;
            skid_tag_reg <= in_tag;
         end
      end
   end

   assign out_imm = out_imm_reg;
   assign out_err = out_err_reg;
   assign out_tag = out_tag_reg;

endmodule
